bf_stage_sched: RTL and testbench

Sequencer for the in-place, memory-based radix-2 DIF FFT built around the registered `BF` butterfly.
- Per stage, it issues every butterfly's read-address pair and twiddle index to the sample RAM and twiddle ROM.
- It delays the same address pair so it is presented as the write-back address when the butterfly result arrives.
- It drains the pipeline between stages and signals completion of all `LOG2N` stages.
- It sits between the FFT top-level control and the RAM/`BF` datapath; it has no data path of its own.

---
 rtl/bf_stage_sched_if.sv | 32 +++
 rtl/bf_stage_sched.sv | 143 ++++++++++++++
 tb/tb_bf_stage_sched.sv | 261 ++++++++++++++++++++++++++
 3 files changed

// File: rtl/bf_stage_sched_if.sv
// Control/address bundle between the FFT stage sequencer and the RAM/BF datapath.
// master = FFT top-level control side, slave = sequencer side.
interface bf_stage_sched_if #(
  parameter int LOG2N = 7,
  parameter int STW   = 3
);
  logic             start;
  logic             busy;
  logic             done;
  logic [STW-1:0]   stage;
  logic             rd_en;
  logic [LOG2N-1:0] rd_addr_up;
  logic [LOG2N-1:0] rd_addr_dn;
  logic [LOG2N-2:0] tw_addr;
  logic             wr_en;
  logic [LOG2N-1:0] wr_addr_up;
  logic [LOG2N-1:0] wr_addr_dn;

  modport master (
    output start,
    input  busy, done, stage,
    input  rd_en, rd_addr_up, rd_addr_dn, tw_addr,
    input  wr_en, wr_addr_up, wr_addr_dn
  );

  modport slave (
    input  start,
    output busy, done, stage,
    output rd_en, rd_addr_up, rd_addr_dn, tw_addr,
    output wr_en, wr_addr_up, wr_addr_dn
  );
endinterface

// File: rtl/bf_stage_sched.sv
// Stage/butterfly sequencer for an in-place radix-2 DIF FFT: issues read and
// twiddle addresses per butterfly and replays them PIPE cycles later as write-back.
module bf_stage_sched #(
  parameter int N     = 128,
  parameter int LOG2N = 7,
  parameter int STW   = 3,
  parameter int PIPE  = 2
) (
  input logic            clk,
  input logic            rst,
  bf_stage_sched_if.slave bus
);

  localparam int unsigned KW = LOG2N - 1;
  localparam int unsigned DW = (PIPE > 1) ? $clog2(PIPE) : 1;
  localparam logic [KW-1:0]  K_LAST = KW'(N / 2 - 1);
  localparam logic [STW-1:0] S_LAST = STW'(LOG2N - 1);
  localparam logic [DW-1:0]  D_LOAD = DW'(PIPE - 1);

  typedef enum logic [1:0] {IDLE, RUN, DRAIN, DONE} state_t;

  state_t           state, nxt_state;
  logic [KW-1:0]    k, nxt_k;
  logic [STW-1:0]   stage, nxt_stage;
  logic [DW-1:0]    dcnt, nxt_dcnt;

  logic [LOG2N-1:0] span, mask, kx, nxt_up, nxt_dn;
  logic [KW-1:0]    nxt_tw;

  logic             busy_q, done_q, rd_en_q;
  logic [LOG2N-1:0] rd_up_q, rd_dn_q;
  logic [KW-1:0]    tw_q;

  logic             sr_en [PIPE];
  logic [LOG2N-1:0] sr_up [PIPE];
  logic [LOG2N-1:0] sr_dn [PIPE];

  always_comb begin
    nxt_state = state;
    nxt_k     = k;
    nxt_stage = stage;
    nxt_dcnt  = dcnt;
    case (state)
      IDLE: begin
        if (bus.start) begin
          nxt_state = RUN;
          nxt_k     = '0;
          nxt_stage = '0;
        end
      end
      RUN: begin
        if (k == K_LAST) begin
          nxt_state = DRAIN;
          nxt_dcnt  = D_LOAD;
        end else begin
          nxt_k = k + KW'(1);
        end
      end
      DRAIN: begin
        if (dcnt == '0) begin
          if (stage == S_LAST) begin
            nxt_state = DONE;
          end else begin
            nxt_state = RUN;
            nxt_stage = stage + STW'(1);
            nxt_k     = '0;
          end
        end else begin
          nxt_dcnt = dcnt - DW'(1);
        end
      end
      DONE: begin
        nxt_state = IDLE;
        nxt_stage = '0;
      end
      default: nxt_state = IDLE;
    endcase
  end

  // span is a power of two, so k splits into group bits (above span) and
  // position bits (below); doubling the group bits inserts the span-sized gap.
  always_comb begin
    span   = LOG2N'(N >> (int'(nxt_stage) + 1));
    mask   = span - LOG2N'(1);
    kx     = {1'b0, nxt_k};
    nxt_up = ((kx & ~mask) << 1) | (kx & mask);
    nxt_dn = nxt_up | span;
    nxt_tw = KW'((kx & mask) << nxt_stage);
  end

  // Outputs are registered from next-state values so rd_en lines up with the
  // first RUN cycle; the write-back line taps the current registered read.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state   <= IDLE;
      k       <= '0;
      stage   <= '0;
      dcnt    <= '0;
      busy_q  <= 1'b0;
      done_q  <= 1'b0;
      rd_en_q <= 1'b0;
      rd_up_q <= '0;
      rd_dn_q <= '0;
      tw_q    <= '0;
      for (int unsigned i = 0; i < PIPE; i++) begin
        sr_en[i] <= 1'b0;
        sr_up[i] <= '0;
        sr_dn[i] <= '0;
      end
    end else begin
      state   <= nxt_state;
      k       <= nxt_k;
      stage   <= nxt_stage;
      dcnt    <= nxt_dcnt;
      busy_q  <= (nxt_state == RUN) || (nxt_state == DRAIN);
      done_q  <= (nxt_state == DONE);
      rd_en_q <= (nxt_state == RUN);
      rd_up_q <= (nxt_state == RUN) ? nxt_up : '0;
      rd_dn_q <= (nxt_state == RUN) ? nxt_dn : '0;
      tw_q    <= (nxt_state == RUN) ? nxt_tw : '0;
      sr_en[0] <= rd_en_q;
      sr_up[0] <= rd_up_q;
      sr_dn[0] <= rd_dn_q;
      for (int unsigned i = 1; i < PIPE; i++) begin
        sr_en[i] <= sr_en[i-1];
        sr_up[i] <= sr_up[i-1];
        sr_dn[i] <= sr_dn[i-1];
      end
    end
  end

  assign bus.busy       = busy_q;
  assign bus.done       = done_q;
  assign bus.stage      = stage;
  assign bus.rd_en      = rd_en_q;
  assign bus.rd_addr_up = rd_up_q;
  assign bus.rd_addr_dn = rd_dn_q;
  assign bus.tw_addr    = tw_q;
  assign bus.wr_en      = sr_en[PIPE-1];
  assign bus.wr_addr_up = sr_up[PIPE-1];
  assign bus.wr_addr_dn = sr_dn[PIPE-1];

endmodule

// File: tb/tb_bf_stage_sched.sv
// Bench for bf_stage_sched: N=8 and N=128 instances checked cycle by cycle
// against a schedule model built from stage/butterfly arithmetic.
module tb_bf_stage_sched;

  localparam int PIPE = 2;

  logic clk = 1'b0;
  logic rst = 1'b0;
  always #5 clk = ~clk;

  bf_stage_sched_if #(.LOG2N(3), .STW(2)) if8 ();
  bf_stage_sched_if #(.LOG2N(7), .STW(3)) if128 ();

  bf_stage_sched #(.N(8), .LOG2N(3), .STW(2), .PIPE(PIPE)) u8 (
    .clk(clk), .rst(rst), .bus(if8)
  );
  bf_stage_sched #(.N(128), .LOG2N(7), .STW(3), .PIPE(PIPE)) u128 (
    .clk(clk), .rst(rst), .bus(if128)
  );

  int n_cmp = 0;
  int n_err = 0;

  typedef struct {
    int busy, done, stage, rd, up, dn, tw, wr, wup, wdn;
  } exp_t;

  function automatic void bf_pair(input int n, input int s, input int k,
                                  output int up, output int dn, output int tw);
    int span;
    span = n >> (s + 1);
    up   = (k / span) * 2 * span + (k % span);
    dn   = up + span;
    tw   = ((k % span) << s) % (n / 2);
  endfunction

  // Expected outputs at cycle t, where t=0 is the cycle after start is accepted.
  function automatic exp_t model(input int n, input int lg, input int t);
    exp_t e;
    int per, total, tr, a, b, c;
    per   = n / 2 + PIPE;
    total = lg * per;
    e.busy = 0; e.done = 0; e.stage = -1; e.rd = 0; e.up = 0; e.dn = 0;
    e.tw = 0; e.wr = 0; e.wup = 0; e.wdn = 0;
    if (t >= 0 && t < total) begin
      e.busy  = 1;
      e.stage = t / per;
      if (t % per < n / 2) begin
        bf_pair(n, t / per, t % per, a, b, c);
        e.rd = 1; e.up = a; e.dn = b; e.tw = c;
      end
    end
    e.done = (t == total) ? 1 : 0;
    tr = t - PIPE;
    if (tr >= 0 && tr < total && (tr % per) < n / 2) begin
      bf_pair(n, tr / per, tr % per, a, b, c);
      e.wr = 1; e.wup = a; e.wdn = b;
    end
    return e;
  endfunction

  task automatic cyc();
    @(posedge clk);
    #1;
  endtask

  // One full N=8 run from start; optional stray starts, optional early exit.
  task automatic run8(input string tag, input bit stray, input int abort_t);
    exp_t e;
    logic [17:0] obs, expv;
    int n_wr, n_busy, n_done;
    n_wr = 0; n_busy = 0; n_done = 0;
    if8.start = 1'b1;
    cyc();
    for (int t = 0; t <= 19; t++) begin
      e = model(8, 3, t);
      obs = {if8.busy, if8.done, if8.rd_en, if8.rd_addr_up, if8.rd_addr_dn,
             if8.tw_addr, if8.wr_en, if8.wr_addr_up, if8.wr_addr_dn};
      expv = {1'(e.busy), 1'(e.done), 1'(e.rd), 3'(e.up), 3'(e.dn), 2'(e.tw),
              1'(e.wr), 3'(e.wup), 3'(e.wdn)};
      n_cmp++;
      if (obs !== expv) begin
        n_err++;
        $display("FAIL %s t=%0d outputs got=%h exp=%h", tag, t, obs, expv);
      end
      if (e.stage >= 0) begin
        n_cmp++;
        if (if8.stage !== 2'(e.stage)) begin
          n_err++;
          $display("FAIL %s t=%0d stage got=%0d exp=%0d", tag, t, if8.stage, e.stage);
        end
      end
      if (if8.wr_en) n_wr++;
      if (if8.busy) n_busy++;
      if (if8.done) n_done++;
      if (t == abort_t) begin
        if8.start = 1'b0;
        return;
      end
      if (t == 19) begin
        if8.start = 1'b0;
        break;
      end
      if8.start = stray && (t == 1 || t == 4 || t == 18 || $urandom_range(0, 3) == 0);
      cyc();
    end
    n_cmp++;
    if (n_wr != 12) begin
      n_err++;
      $display("FAIL %s wr_en_count got=%0d exp=12", tag, n_wr);
    end
    n_cmp++;
    if (n_busy != 18) begin
      n_err++;
      $display("FAIL %s busy_count got=%0d exp=18", tag, n_busy);
    end
    n_cmp++;
    if (n_done != 1) begin
      n_err++;
      $display("FAIL %s done_count got=%0d exp=1", tag, n_done);
    end
  endtask

  task automatic test_reset();
    logic [17:0] o8;
    logic [37:0] o128;
    @(posedge clk);
    #3 rst = 1'b1;
    #1;
    for (int c = 0; c < 6; c++) begin
      o8 = {if8.busy, if8.done, if8.rd_en, if8.rd_addr_up, if8.rd_addr_dn,
            if8.tw_addr, if8.wr_en, if8.wr_addr_up, if8.wr_addr_dn};
      o128 = {if128.busy, if128.done, if128.rd_en, if128.rd_addr_up, if128.rd_addr_dn,
              if128.tw_addr, if128.wr_en, if128.wr_addr_up, if128.wr_addr_dn};
      n_cmp++;
      if (o8 !== '0 || if8.stage !== '0) begin
        n_err++;
        $display("FAIL reset8 c=%0d got=%h/%0d exp=0", c, o8, if8.stage);
      end
      n_cmp++;
      if (o128 !== '0 || if128.stage !== '0) begin
        n_err++;
        $display("FAIL reset128 c=%0d got=%h/%0d exp=0", c, o128, if128.stage);
      end
      if (c == 0) begin
        cyc();
        rst = 1'b0;
      end else begin
        cyc();
      end
    end
  endtask

  task automatic test_stage_sequence();
    run8("nominal", 1'b0, -1);
  endtask

  task automatic test_stray_start();
    repeat ($urandom_range(0, 3)) cyc();
    run8("stray", 1'b1, -1);
  endtask

  task automatic test_back_to_back();
    repeat ($urandom_range(1, 3)) cyc();
    run8("b2b_first", 1'b0, -1);
    run8("b2b_second", 1'b0, -1);
  endtask

  task automatic test_abort();
    int ab;
    logic [17:0] o8;
    repeat ($urandom_range(1, 3)) cyc();
    ab = $urandom_range(7, 10);
    run8("pre_abort", 1'b0, ab);
    #2 rst = 1'b1;
    for (int c = 0; c < 5; c++) begin
      if (c == 0) #1;
      o8 = {if8.busy, if8.done, if8.rd_en, if8.rd_addr_up, if8.rd_addr_dn,
            if8.tw_addr, if8.wr_en, if8.wr_addr_up, if8.wr_addr_dn};
      n_cmp++;
      if (o8 !== '0) begin
        n_err++;
        $display("FAIL abort c=%0d outputs got=%h exp=0", c, o8);
      end
      cyc();
      if (c == 0) #2 rst = 1'b0;
    end
    run8("post_abort", 1'b0, -1);
  endtask

  task automatic test_default_size();
    exp_t e;
    logic [37:0] obs, expv;
    int rd_per[7];
    int last_up, last_dn, n_busy;
    for (int s = 0; s < 7; s++) rd_per[s] = 0;
    last_up = -1; last_dn = -1; n_busy = 0;
    if128.start = 1'b1;
    cyc();
    if128.start = 1'b0;
    for (int t = 0; t <= 463; t++) begin
      e = model(128, 7, t);
      obs = {if128.busy, if128.done, if128.rd_en, if128.rd_addr_up, if128.rd_addr_dn,
             if128.tw_addr, if128.wr_en, if128.wr_addr_up, if128.wr_addr_dn};
      expv = {1'(e.busy), 1'(e.done), 1'(e.rd), 7'(e.up), 7'(e.dn), 6'(e.tw),
              1'(e.wr), 7'(e.wup), 7'(e.wdn)};
      n_cmp++;
      if (obs !== expv) begin
        n_err++;
        $display("FAIL n128 t=%0d outputs got=%h exp=%h", t, obs, expv);
      end
      if (e.stage >= 0) begin
        n_cmp++;
        if (if128.stage !== 3'(e.stage)) begin
          n_err++;
          $display("FAIL n128 t=%0d stage got=%0d exp=%0d", t, if128.stage, e.stage);
        end
      end
      if (if128.busy) n_busy++;
      if (if128.rd_en && int'(if128.stage) < 7) begin
        rd_per[int'(if128.stage)]++;
        if (int'(if128.stage) == 6) begin
          last_up = int'(if128.rd_addr_up);
          last_dn = int'(if128.rd_addr_dn);
        end
      end
      if (t < 463) cyc();
    end
    for (int s = 0; s < 7; s++) begin
      n_cmp++;
      if (rd_per[s] != 64) begin
        n_err++;
        $display("FAIL n128 rd_count stage=%0d got=%0d exp=64", s, rd_per[s]);
      end
    end
    n_cmp++;
    if (last_up != 126 || last_dn != 127) begin
      n_err++;
      $display("FAIL n128 last_pair got=(%0d,%0d) exp=(126,127)", last_up, last_dn);
    end
    n_cmp++;
    if (n_busy != 462) begin
      n_err++;
      $display("FAIL n128 busy_count got=%0d exp=462", n_busy);
    end
  endtask

  initial begin
    if8.start   = 1'b0;
    if128.start = 1'b0;
    test_reset();
    test_stage_sequence();
    test_stray_start();
    test_back_to_back();
    test_abort();
    test_default_size();
    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
    $finish;
  end

endmodule
